// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and constants for the sequential ALU.
//   op_t    : 3-bit operation encodings seen on the op input
//   state_t : controller states (IDLE, ITER, FIN)
//   OP_W    : width of the op field
package seq_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOP = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the operand capture logic
// (master) and the sequential ALU (slave).
//   start, op, a, b          : request, driven by the master
//   busy, done               : handshake status, driven by the ALU
//   result, zero, carry, dz  : registered result and flags, driven by the ALU
interface seq_alu_if #(
  parameter int WIDTH = 4
);
  import seq_alu_pkg::*;

  logic               start;
  logic [OP_W-1:0]    op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               zero;
  logic               carry;
  logic               dz;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, carry, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, carry, dz
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared iterative datapath for shift-add multiply and
// restoring divide. A single (WIDTH+2)-bit adder serves both modes.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture operands and clear the accumulator
//   step       : perform one iteration
//   mode       : 0 = multiply, 1 = divide
//   opa, opb   : operands A and B (used on load)
//   acc_nxt    : accumulator value after the current step
//                (product high half / remainder)
//   quo_nxt    : quotient register value after the current step
//                (product low half / quotient)
module alu_muldiv_iter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  // Multiplicand in MUL mode, divisor in DIV mode.
  logic [WIDTH-1:0] m_q, m_d;

  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH+1:0] add_cin;
  logic [WIDTH+1:0] add_sum;
  logic             div_ge;

  // DIV computes {acc, quo msb} - m as add_a + ~m + 1; bit WIDTH+1 of the
  // sum is then the "no borrow" flag, i.e. partial remainder >= divisor.
  always_comb begin
    if (mode) begin
      add_a   = {acc_q, quo_q[WIDTH-1]};
      add_b   = ~{1'b0, m_q};
      add_cin = (WIDTH+2)'(1);
    end else begin
      add_a   = {1'b0, acc_q};
      add_b   = quo_q[0] ? {1'b0, m_q} : '0;
      add_cin = '0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + add_cin;
  end

  assign div_ge = add_sum[WIDTH+1];

  always_comb begin
    if (mode) begin
      acc_nxt = div_ge ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], div_ge};
    end else begin
      // {carry, acc, quo} shifts right by one each step.
      acc_nxt = add_sum[WIDTH:1];
      quo_nxt = {add_sum[0], quo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    quo_d = quo_q;
    m_d   = m_q;
    if (load) begin
      acc_d = '0;
      quo_d = mode ? opa : opb;
      m_d   = mode ? opb : opa;
    end else if (step) begin
      acc_d = acc_nxt;
      quo_d = quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      quo_q <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      quo_q <= quo_d;
      m_q   <= m_d;
    end
  end

endmodule

// File: rtl/seq_alu_core.sv
// seq_alu_core: multi-cycle ALU with start/busy/done handshake.
//   ADD/SUB/AND/OR/XOR/NOP and DIV-by-zero finish one cycle after accept;
//   MUL (shift-add) and DIV (restoring) take WIDTH+1 cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seq_alu_if slave (start/op/a/b in; busy/done/result/flags out)
// Build option: SEQ_ALU_SAT_EN makes ADD/SUB saturate (carry stays raw).
//
// state | meaning
// IDLE  | waiting for start; result/flags hold
// ITER  | one MUL/DIV iteration per cycle, counter 0..WIDTH-1
// FIN   | done pulse, result/flags valid; returns to IDLE
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               dz_q, dz_d;
  logic               is_div_q, is_div_d;

  op_t                op_in;
  logic               start_iter;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] sc_result;
  logic               sc_carry;
  logic               sc_dz;

  logic               dp_load;
  logic               dp_step;
  logic               dp_mode;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  assign op_in      = op_t'(bus.op);
  assign start_iter = (op_in == OP_MUL) || ((op_in == OP_DIV) && (bus.b != '0));
  assign add_sum    = {1'b0, bus.a} + {1'b0, bus.b};
  // Bit WIDTH of the difference is the borrow (a < b).
  assign sub_diff   = {1'b0, bus.a} - {1'b0, bus.b};

  // Single-cycle results, including the DIV-by-zero short cut.
  always_comb begin
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_dz     = 1'b0;
    unique case (op_in)
      OP_ADD: begin
        sc_carry = add_sum[WIDTH];
`ifdef SEQ_ALU_SAT_EN
        sc_result = add_sum[WIDTH] ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                   : {{(WIDTH-1){1'b0}}, add_sum};
`else
        sc_result = {{(WIDTH-1){1'b0}}, add_sum};
`endif
      end
      OP_SUB: begin
        sc_carry = sub_diff[WIDTH];
`ifdef SEQ_ALU_SAT_EN
        sc_result = sub_diff[WIDTH] ? '0 : {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
`else
        sc_result = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
`endif
      end
      OP_DIV: begin
        sc_result = {bus.a, {WIDTH{1'b1}}};
        sc_dz     = 1'b1;
      end
      OP_AND:  sc_result = {{WIDTH{1'b0}}, bus.a & bus.b};
      OP_OR:   sc_result = {{WIDTH{1'b0}}, bus.a | bus.b};
      OP_XOR:  sc_result = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      default: sc_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    dz_d     = dz_q;
    is_div_d = is_div_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    dp_mode  = is_div_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (start_iter) begin
            state_d  = ITER;
            cnt_d    = '0;
            is_div_d = (op_in == OP_DIV);
            dp_mode  = (op_in == OP_DIV);
            dp_load  = 1'b1;
          end else begin
            state_d  = FIN;
            done_d   = 1'b1;
            result_d = sc_result;
            zero_d   = (sc_result == '0);
            carry_d  = sc_carry;
            dz_d     = sc_dz;
          end
        end
      end
      ITER: begin
        dp_step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Capture the last step's value directly so done lines up
          // with the FIN cycle.
          state_d  = FIN;
          done_d   = 1'b1;
          result_d = {acc_nxt, quo_nxt};
          zero_d   = ({acc_nxt, quo_nxt} == '0);
          carry_d  = 1'b0;
          dz_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      dz_q     <= dz_d;
      is_div_q <= is_div_d;
    end
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (dp_load),
    .step    (dp_step),
    .mode    (dp_mode),
    .opa     (bus.a),
    .opb     (bus.b),
    .acc_nxt (acc_nxt),
    .quo_nxt (quo_nxt)
  );

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;
  assign bus.dz     = dz_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Testbench for seq_alu_core: a WIDTH=4 instance checked every cycle against
// a behavioural model, plus a WIDTH=8 instance checked per operation.
// Honours SEQ_ALU_SAT_EN when defined.
module tb_seq_alu_core;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_alu_if #(.WIDTH(4)) bus ();
  seq_alu_if #(.WIDTH(8)) bus8 ();

  seq_alu_core #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seq_alu_core #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit zero;
    bit carry;
    bit dz;
    int lat;
  } exp_t;

  // Expected outcome of one operation, straight from the arithmetic rules.
  function automatic exp_t model(input int op, input int a, input int b, input int w);
    exp_t e;
    int   mask;
    mask  = (1 << w) - 1;
    e     = '{default: 0};
    e.lat = 1;
    case (op)
      0: begin
        e.res   = a + b;
        e.carry = (a + b) > mask;
`ifdef SEQ_ALU_SAT_EN
        if (e.carry) e.res = mask;
`endif
      end
      1: begin
        e.carry = a < b;
        e.res   = (a - b) & mask;
`ifdef SEQ_ALU_SAT_EN
        if (e.carry) e.res = 0;
`endif
      end
      2: begin
        e.res = a * b;
        e.lat = w + 1;
      end
      3: begin
        if (b == 0) begin
          e.res = (a << w) | mask;
          e.dz  = 1;
        end else begin
          e.res = ((a % b) << w) | (a / b);
          e.lat = w + 1;
        end
      end
      4: e.res = a & b;
      5: e.res = a | b;
      6: e.res = a ^ b;
      default: e.res = 0;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-level expectations for the WIDTH=4 instance: cycles left in the
  // current operation, and the outputs it must show.
  int   m_left = 0;
  exp_t m_pend;
  bit   m_busy = 0;
  bit   m_done = 0;
  int   m_res = 0;
  bit   m_zero = 0;
  bit   m_carry = 0;
  bit   m_dz = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = 0;
      m_busy  = 0;
      m_done  = 0;
      m_res   = 0;
      m_zero  = 0;
      m_carry = 0;
      m_dz    = 0;
    end else begin
      if (m_left > 0) begin
        m_left--;
      end else if (bus.start) begin
        m_pend = model(int'(bus.op), int'(bus.a), int'(bus.b), 4);
        m_left = m_pend.lat;
      end
      m_busy = (m_left > 0);
      m_done = (m_left == 1);
      if (m_done) begin
        m_res   = m_pend.res;
        m_zero  = m_pend.zero;
        m_carry = m_pend.carry;
        m_dz    = m_pend.dz;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",   32'(bus.busy),   32'(m_busy));
    chk("done",   32'(bus.done),   32'(m_done));
    chk("result", 32'(bus.result), m_res);
    chk("zero",   32'(bus.zero),   32'(m_zero));
    chk("carry",  32'(bus.carry),  32'(m_carry));
    chk("dz",     32'(bus.dz),     32'(m_dz));
  end

  // Issue one op on the WIDTH=4 instance and wait for done; optionally keep
  // start high with fresh random operands while the op is in flight.
  task automatic run4(input int op, input int a, input int b, input bit hold, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'(op);
    bus.a     = 4'(a);
    bus.b     = 4'(b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (hold) begin
        bus.op = 3'($urandom_range(0, 7));
        bus.a  = 4'($urandom_range(0, 15));
        bus.b  = 4'($urandom_range(0, 15));
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && lat < 40);
    bus.start = 1'b0;
    chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic run8(input int op, input int a, input int b, output int lat);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.op    = 3'(op);
    bus8.a     = 8'(a);
    bus8.b     = 8'(b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus8.start = 1'b0;
    end while (!bus8.done && lat < 40);
    chk("done8_timeout", 32'(bus8.done), 32'd1);
  endtask

  initial begin
    int   lat;
    int   nd;
    int   op, a, b;
    exp_t e;

    rst_n = 1'b0;
    bus.start = 1'b0;  bus.op = '0;  bus.a = '0;  bus.b = '0;
    bus8.start = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_done",   32'(bus.done),   32'h0);
    chk("rst_result8", 32'(bus8.result), 32'h0);

    run4(0, 9, 8, 1'b0, lat);
    chk("add_lat", lat, 1);
`ifdef SEQ_ALU_SAT_EN
    chk("add_res", 32'(bus.result), 32'h0F);
`else
    chk("add_res", 32'(bus.result), 32'h11);
`endif
    chk("add_carry", 32'(bus.carry), 32'd1);
    chk("add_zero",  32'(bus.zero),  32'd0);

    run4(1, 3, 5, 1'b0, lat);
`ifdef SEQ_ALU_SAT_EN
    chk("sub_res",  32'(bus.result), 32'h00);
    chk("sub_zero", 32'(bus.zero),   32'd1);
`else
    chk("sub_res",  32'(bus.result), 32'h0E);
    chk("sub_zero", 32'(bus.zero),   32'd0);
`endif
    chk("sub_carry", 32'(bus.carry), 32'd1);

    run4(2, 15, 15, 1'b1, lat);
    chk("mul_lat", lat, 5);
    chk("mul_res", 32'(bus.result), 32'hE1);

    run4(3, 13, 4, 1'b0, lat);
    chk("div_lat", lat, 5);
    chk("div_res", 32'(bus.result), 32'h13);
    chk("div_dz",  32'(bus.dz), 32'd0);

    run4(3, 7, 0, 1'b0, lat);
    chk("dz_lat", lat, 1);
    chk("dz_res", 32'(bus.result), 32'h7F);
    chk("dz_dz",  32'(bus.dz), 32'd1);

    run4(7, 5, 9, 1'b0, lat);
    chk("nop_res",  32'(bus.result), 32'h0);
    chk("nop_zero", 32'(bus.zero), 32'd1);

    // Reset two cycles into a multiply.
    run4(6, 10, 3, 1'b0, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 4'd15; bus.b = 4'd15;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_busy",   32'(bus.busy),   32'h0);
    chk("mrst_done",   32'(bus.done),   32'h0);
    chk("mrst_result", 32'(bus.result), 32'h0);
    chk("mrst_dz",     32'(bus.dz),     32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("mrst_no_done", nd, 0);
    run4(0, 1, 1, 1'b0, lat);
    chk("post_rst_add", 32'(bus.result), 32'h02);

    run8(3, 255, 16, lat);
    chk("div8_lat", lat, 9);
    chk("div8_res", 32'(bus8.result), 32'h0F0F);
    chk("div8_dz",  32'(bus8.dz), 32'd0);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, 15);
      b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15);
      e  = model(op, a, b, 4);
      run4(op, a, b, ($urandom_range(0, 3) == 0), lat);
      chk("rand_lat", lat, e.lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
      e  = model(op, a, b, 8);
      run8(op, a, b, lat);
      chk("r8_lat",    lat, e.lat);
      chk("r8_result", 32'(bus8.result), e.res);
      chk("r8_zero",   32'(bus8.zero),   32'(e.zero));
      chk("r8_carry",  32'(bus8.carry),  32'(e.carry));
      chk("r8_dz",     32'(bus8.dz),     32'(e.dz));
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
